// File: rtl/bist_pkg.sv
// Shared definitions for the full-adder self-test sequencer: FSM state
// encoding, pattern/signature widths and the default golden signature.
package bist_pkg;

    localparam int PAT_W = 3;   // {a,b,cin}
    localparam int SIG_W = 4;   // MISR signature width
    localparam int CNT_W = 4;   // pattern counter width, wide enough never to wrap

    localparam logic [SIG_W-1:0] GOLDEN_SIG_DEFAULT = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // States in which the CUT is driven by the pattern generator
    function automatic logic is_test_state(input state_t s);
        return (s == ST_INIT) || (s == ST_RUN) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/bist_pattern_counter.sv
// Pattern counter for the self-test run: synchronous clear, count enable,
// and a terminal flag raised while the count equals the last pattern index.
module bist_pattern_counter
    import bist_pkg::*;
#(
    parameter int LAST = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    // Clear has priority so INIT always starts the run from pattern 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST_CNT);

endmodule

// File: rtl/bist_controller.sv
// Self-test sequencer for the 1-bit full adder: muxes patterns into the CUT,
// clears the MISR, runs exhaustive patterns and compares the final signature.
// Optional feature macro: BIST_AUTORUN_EN (one automatic run after each reset).
module bist_controller
    import bist_pkg::*;
#(
    parameter int               PATTERNS   = 8,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = GOLDEN_SIG_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] func_abc,
    input  logic [SIG_W-1:0] signature,
    output logic [PAT_W-1:0] cut_abc,
    output logic             test_mode,
    output logic             ora_reset,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic             terminal;
    logic             start_go;
    logic             ora_reset_q;
    logic             unused_count_msb;

    bist_pattern_counter #(
        .LAST(PATTERNS - 1)
    ) u_counter (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ST_INIT),
        .enable  (state == ST_RUN),
        .count   (count),
        .terminal(terminal)
    );

    // Only the low bits select the pattern; the top bit keeps the count from wrapping
    assign unused_count_msb = count[CNT_W-1];

`ifdef BIST_AUTORUN_EN
    logic autorun_pending;

    // One free run per reset: cleared the first time IDLE is left
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            autorun_pending <= 1'b1;
        end else if (state == ST_IDLE) begin
            autorun_pending <= 1'b0;
        end
    end

    assign start_go = start | autorun_pending;
`else
    assign start_go = start;
`endif

    // Next-state decode; start is only looked at in IDLE and DONE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (start_go) next_state = ST_INIT;
            ST_INIT:    next_state = ST_RUN;
            ST_RUN:     if (terminal) next_state = ST_CAPTURE;
            ST_CAPTURE: next_state = ST_DONE;
            ST_DONE:    if (start) next_state = ST_INIT;
            default:    next_state = ST_IDLE;
        endcase
    end

    // State register and registered outputs decoded from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            test_mode   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            ora_reset_q <= 1'b0;
        end else begin
            state       <= next_state;
            test_mode   <= is_test_state(next_state);
            busy        <= is_test_state(next_state);
            done        <= (next_state == ST_DONE);
            ora_reset_q <= (next_state == ST_INIT);
            if (next_state == ST_INIT) begin
                pass <= 1'b0;
            end else if (state == ST_CAPTURE) begin
                pass <= (signature == GOLDEN_SIG);
            end
        end
    end

    // The ORA is held clear while system reset is asserted and during INIT
    assign ora_reset = ora_reset_q | reset;

    assign cut_abc = test_mode ? count[PAT_W-1:0] : func_abc;

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller with a behavioural full adder and
// 4-bit MISR around it; expected patterns/signatures/pass go into queues.
module tb_bist_controller;

    localparam int PATTERNS = 8;

    logic       clock;
    logic       reset;
    logic       start;
    logic [2:0] func_abc;
    logic [3:0] signature;
    logic [2:0] cut_abc;
    logic       test_mode;
    logic       ora_reset;
    logic       busy;
    logic       done;
    logic       pass;

    logic       fault_sa0;
    logic       cut_sum;
    logic       cut_cout;

    int checks = 0;
    int fails  = 0;

    logic [2:0] exp_q[$];
    logic       pass_q[$];
    logic [3:0] sig_q[$];

    bist_controller #(
        .PATTERNS  (PATTERNS),
        .GOLDEN_SIG(4'b1011)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .func_abc (func_abc),
        .signature(signature),
        .cut_abc  (cut_abc),
        .test_mode(test_mode),
        .ora_reset(ora_reset),
        .busy     (busy),
        .done     (done),
        .pass     (pass)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Full adder CUT with optional sum stuck-at-0
    assign cut_sum  = fault_sa0 ? 1'b0 : ^cut_abc;
    assign cut_cout = (cut_abc[2] & cut_abc[1]) | (cut_abc[2] & cut_abc[0]) | (cut_abc[1] & cut_abc[0]);

    // 4-bit MISR (x^4+x+1): sum into Q0, carry into Q1
    always @(posedge clock or posedge ora_reset) begin
        if (ora_reset) signature <= 4'b0000;
        else signature <= {signature[2], signature[1],
                           signature[0] ^ signature[3] ^ cut_cout,
                           signature[3] ^ cut_sum};
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_run(input logic exp_pass, input logic [3:0] exp_sig);
        for (int k = 0; k < PATTERNS; k++) exp_q.push_back(3'(k));
        pass_q.push_back(exp_pass);
        sig_q.push_back(exp_sig);
    endtask

    // Walks one run from the edge that samples start through DONE
    task automatic check_run(input string tag, input bit hold_start);
        logic [2:0] exp_pat;
        logic       exp_p;
        logic [3:0] exp_s;
        step();
        if (!hold_start) start = 1'b0;
        checks++;
        if (busy !== 1'b1 || test_mode !== 1'b1 || ora_reset !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin
            fails++;
            $display("FAIL %s_init: busy=%b test_mode=%b ora_reset=%b done=%b pass=%b, required 1 1 1 0 0",
                     tag, busy, test_mode, ora_reset, done, pass);
        end
        for (int k = 0; k < PATTERNS; k++) begin
            step();
            func_abc = 3'($urandom_range(0, 7));
            #1;
            exp_pat = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
            checks++;
            if (cut_abc !== exp_pat || test_mode !== 1'b1 || ora_reset !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL %s_run%0d: cut_abc=%b test_mode=%b ora_reset=%b done=%b, required %b 1 0 0",
                         tag, k, cut_abc, test_mode, ora_reset, done, exp_pat);
            end
        end
        step();
        exp_s = (sig_q.size() > 0) ? sig_q.pop_front() : 4'bxxxx;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || signature !== exp_s) begin
            fails++;
            $display("FAIL %s_capture: busy=%b done=%b signature=%b, required 1 0 %b",
                     tag, busy, done, signature, exp_s);
        end
        step();
        exp_p = (pass_q.size() > 0) ? pass_q.pop_front() : 1'bx;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || test_mode !== 1'b0 || pass !== exp_p || cut_abc !== func_abc) begin
            fails++;
            $display("FAIL %s_done: done=%b busy=%b test_mode=%b pass=%b cut_abc=%b, required 1 0 0 %b %b",
                     tag, done, busy, test_mode, pass, cut_abc, exp_p, func_abc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        func_abc = 3'b000;
        fault_sa0 = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || test_mode !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy_mode: busy=%b test_mode=%b, required 0 0", busy, test_mode);
        end
        checks++;
        if (done !== 1'b0 || pass !== 1'b0) begin
            fails++;
            $display("FAIL reset_done_pass: done=%b pass=%b, required 0 0", done, pass);
        end
        checks++;
        if (ora_reset !== 1'b1) begin
            fails++;
            $display("FAIL reset_ora: ora_reset=%b, required 1", ora_reset);
        end
`ifndef BIST_AUTORUN_EN
        reset = 1'b0;
        step();
        checks++;
        if (ora_reset !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || test_mode !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_idle: ora_reset=%b busy=%b done=%b test_mode=%b, required 0 0 0 0",
                     ora_reset, busy, done, test_mode);
        end
`endif
    endtask

`ifdef BIST_AUTORUN_EN
    task automatic test_autorun();
        reset = 1'b0;
        start = 1'b0;
        push_run(1'b1, 4'b1011);
        check_run("autorun", 1'b0);
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL autorun_once: busy=%b done=%b, required 0 1", busy, done);
        end
    endtask
`endif

    task automatic test_func_path();
        func_abc = 3'b101;
        #1;
        checks++;
        if (cut_abc !== 3'b101 || test_mode !== 1'b0) begin
            fails++;
            $display("FAIL func_path: cut_abc=%b test_mode=%b, required 101 0", cut_abc, test_mode);
        end
        func_abc = 3'b010;
        #1;
        checks++;
        if (cut_abc !== 3'b010) begin
            fails++;
            $display("FAIL func_path2: cut_abc=%b, required 010", cut_abc);
        end
    endtask

    task automatic test_pass_run();
        start = 1'b1;
        push_run(1'b1, 4'b1011);
        check_run("pass_run", 1'b0);
    endtask

    task automatic test_stuck_fault();
        fault_sa0 = 1'b1;
        start = 1'b1;
        push_run(1'b0, 4'b1000);
        check_run("sum_sa0", 1'b0);
        fault_sa0 = 1'b0;
    endtask

    task automatic test_start_held();
        start = 1'b1;
        push_run(1'b1, 4'b1011);
        check_run("held_first", 1'b1);
        push_run(1'b1, 4'b1011);
        check_run("held_rerun", 1'b0);
        step();
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL held_no_restart: done=%b busy=%b, required 1 0", done, busy);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            step();
            checks++;
            if (cut_abc !== 3'(k)) begin
                fails++;
                $display("FAIL abort_run%0d: cut_abc=%b, required %b", k, cut_abc, 3'(k));
            end
        end
        reset = 1'b1;
        func_abc = 3'b110;
        #1;
        checks++;
        if (busy !== 1'b0 || test_mode !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || ora_reset !== 1'b1 || cut_abc !== 3'b110) begin
            fails++;
            $display("FAIL abort_reset: busy=%b test_mode=%b done=%b pass=%b ora_reset=%b cut_abc=%b, required 0 0 0 0 1 110",
                     busy, test_mode, done, pass, ora_reset, cut_abc);
        end
        step();
        step();
        reset = 1'b0;
`ifdef BIST_AUTORUN_EN
        push_run(1'b1, 4'b1011);
        check_run("abort_autorun", 1'b0);
`else
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            fails++;
            $display("FAIL abort_no_done: activity after abort=1, required 0");
        end
`endif
        start = 1'b1;
        push_run(1'b1, 4'b1011);
        check_run("abort_rerun", 1'b0);
    endtask

    initial begin
        test_reset();
`ifdef BIST_AUTORUN_EN
        test_autorun();
`endif
        test_func_path();
        test_pass_run();
        test_stuck_fault();
        test_func_path();
        test_start_held();
        test_reset_abort();
        checks++;
        if (exp_q.size() != 0 || pass_q.size() != 0 || sig_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: left %0d/%0d/%0d, required 0/0/0",
                     exp_q.size(), pass_q.size(), sig_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
